// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, condition-checked decode, execute,
// memory and write-back control with a retired-instruction counter.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [3:0]  cond,
  input  logic [3:0]  flags,
  input  logic        CPSRwrite,
  input  logic        linkBit,
  input  logic        loadStore,
  input  logic        writeBack,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic        regWrite,
  output logic        flagWrite,
  output logic        linkWrite,
  output logic        baseWrite,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   retire;

  // flags layout is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = !cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cy && !z;
      4'b1001: cond_pass = !cy || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      retired <= 16'd0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + 16'd1;
    end
  end

  assign state = state_q;

  // Outputs are gated by reset so they drop the moment reset asserts.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = 1'b0;
    regWrite  = 1'b0;
    flagWrite = 1'b0;
    linkWrite = 1'b0;
    baseWrite = 1'b0;
    retire    = 1'b0;
    state_d   = FETCH;
    if (reset) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            state_d = DECODE;
          end else begin
            state_d = FETCH;
          end
        end
        DECODE: begin
          // Undefined upper opcodes are retired like the invalid class.
          if (!cond_pass(cond, flags) || (opcode[4] && opcode[3:1] != 3'b000)) begin
            retire = 1'b1;
          end else if (opcode == 5'b10001) begin
            state_d = BRANCH;
          end else begin
            state_d = EXEC;
          end
        end
        BRANCH: begin
          pcWrite   = 1'b1;
          pcSrc     = 1'b1;
          linkWrite = linkBit;
          retire    = 1'b1;
        end
        EXEC: begin
          if (!opcode[4]) begin
            flagWrite = CPSRwrite || (opcode[3:2] == 2'b10);
            if (opcode[3:2] == 2'b10) retire = 1'b1;
            else state_d = WB;
          end else begin
            state_d = MEM;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          memRead  = loadStore;
          memWrite = !loadStore;
          if (dmem_ack) begin
            baseWrite = writeBack;
            if (loadStore) state_d = WB;
            else retire = 1'b1;
          end else begin
            state_d = MEM;
          end
        end
        WB: begin
          regWrite = 1'b1;
          retire   = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instructions, each
// expanded by a reference model into an expected per-cycle trace.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic [4:0]  opcode;
  logic [3:0]  cond;
  logic [3:0]  flags;
  logic        CPSRwrite, linkBit, loadStore, writeBack;
  logic        imem_ack, dmem_ack;
  logic        imem_req, dmem_req, memRead, memWrite, irWrite, pcWrite, pcSrc;
  logic        regWrite, flagWrite, linkWrite, baseWrite;
  logic [2:0]  state;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ret;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cond(cond), .flags(flags),
    .CPSRwrite(CPSRwrite), .linkBit(linkBit), .loadStore(loadStore),
    .writeBack(writeBack), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .regWrite(regWrite), .flagWrite(flagWrite), .linkWrite(linkWrite),
    .baseWrite(baseWrite), .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] obs_ctl;
  assign obs_ctl = {imem_req, dmem_req, memRead, memWrite, irWrite, pcWrite,
                    pcSrc, regWrite, flagWrite, linkWrite, baseWrite};

  typedef struct {
    int          st;
    logic        ia;
    logic        da;
    logic [10:0] ctl;
    bit          ret;
  } cyc_t;

  cyc_t tr[$];

  function automatic logic [10:0] mk(bit ir, bit dr, bit mr, bit mw, bit irw, bit pw,
                                     bit ps, bit rw, bit fw, bit lw, bit bw);
    return {ir, dr, mr, mw, irw, pw, ps, rw, fw, lw, bw};
  endfunction

  // ARM conditions come in pairs: even code is the base test, odd code its inverse.
  function automatic bit model_cond(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(int st, logic ia, logic da, logic [10:0] ctl, bit ret);
    cyc_t c;
    c.st = st; c.ia = ia; c.da = da; c.ctl = ctl; c.ret = ret;
    tr.push_back(c);
  endtask

  // Build the expected trace for one instruction, then drive it cycle by cycle.
  // abort_st >= 0 pulses reset during the first cycle spent in that state.
  task automatic run_instr(logic [4:0] op, logic [3:0] cnd, logic [3:0] flg,
                           logic s, logic lb, logic ls, logic wb,
                           int iw, int dw, int abort_st);
    bit cmp;
    tr.delete();
    opcode = op; cond = cnd; flags = flg;
    CPSRwrite = s; linkBit = lb; loadStore = ls; writeBack = wb;
    for (int k = 0; k < iw; k++) add(0, 1'b0, 1'($urandom_range(0, 1)), mk(1,0,0,0,0,0,0,0,0,0,0), 0);
    add(0, 1'b1, 1'($urandom_range(0, 1)), mk(1,0,0,0,1,1,0,0,0,0,0), 0);
    if (!model_cond(cnd, flg) || !(op < 5'd16 || op == 5'd16 || op == 5'd17)) begin
      add(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 1);
    end else if (op == 5'd17) begin
      add(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 0);
      add(5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(0,0,0,0,0,1,1,0,0,lb,0), 1);
    end else if (op < 5'd16) begin
      cmp = (op >= 5'd8 && op <= 5'd11);
      add(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 0);
      add(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,0,0,s|cmp,0,0), cmp);
      if (!cmp) add(4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,0,1,0,0,0), 1);
    end else begin
      add(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 0);
      add(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0, 0);
      for (int k = 0; k < dw; k++) add(3, 1'($urandom_range(0, 1)), 1'b0, mk(0,1,ls,~ls,0,0,0,0,0,0,0), 0);
      add(3, 1'($urandom_range(0, 1)), 1'b1, mk(0,1,ls,~ls,0,0,0,0,0,0,wb), !ls);
      if (ls) add(4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,0,1,0,0,0), 1);
    end
    foreach (tr[i]) begin
      imem_ack = tr[i].ia;
      dmem_ack = tr[i].da;
      #1;
      chk("state", 16'(state), 16'(tr[i].st));
      chk("ctl", 16'(obs_ctl), 16'(tr[i].ctl));
      chk("retired", retired, exp_ret);
      if (tr[i].st == abort_st) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_ctl", 16'(obs_ctl), 16'd0);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_retired", retired, 16'd0);
        exp_ret = '0;
        @(posedge clk);
        #1 chk("rst_hold_state", 16'(state), 16'd0);
        chk("rst_hold_ctl", 16'(obs_ctl), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        return;
      end
      @(posedge clk);
      if (tr[i].ret) exp_ret = exp_ret + 16'd1;
      @(negedge clk);
    end
  endtask

  initial begin
    int cls;
    logic [4:0] op;
    reset = 1'b0;
    opcode = '0; cond = 4'b1110; flags = '0;
    CPSRwrite = 0; linkBit = 0; loadStore = 0; writeBack = 0;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    exp_ret = '0;
    #1;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_retired", retired, 16'd0);
    chk("reset_ctl", 16'(obs_ctl), 16'd0);
    @(negedge clk);
    chk("reset_state_clk", 16'(state), 16'd0);
    chk("reset_ctl_clk", 16'(obs_ctl), 16'd0);
    reset = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // ADD AL with two fetch wait cycles
    run_instr(5'd4, 4'b1110, 4'b0000, 0, 0, 0, 0, 2, 0, -1);
    chk("add_retired", retired, 16'd1);
    // CMP without S still writes flags and skips WB
    run_instr(5'd10, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, -1);
    // BEQ taken with link, then not taken
    run_instr(5'd17, 4'b0000, 4'b0100, 0, 1, 0, 0, 1, 0, -1);
    run_instr(5'd17, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, -1);
    // LDR with writeback and three data wait cycles, then STR
    run_instr(5'd16, 4'b1110, 4'b0000, 0, 0, 1, 1, 0, 3, -1);
    run_instr(5'd16, 4'b1110, 4'b0000, 0, 0, 0, 0, 1, 1, -1);
    // Invalid opcode and the never condition
    run_instr(5'd31, 4'b1110, 4'b0000, 1, 1, 1, 1, 0, 0, -1);
    run_instr(5'd2, 4'b1111, 4'b1111, 1, 0, 0, 0, 0, 0, -1);
    // Reset during MEM, then during FETCH wait
    run_instr(5'd16, 4'b1110, 4'b0000, 0, 0, 1, 1, 0, 3, 3);
    run_instr(5'd4, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, -1);
    run_instr(5'd4, 4'b1110, 4'b0000, 0, 0, 0, 0, 2, 0, 0);
    chk("post_fetch_rst_retired", retired, 16'd0);

    // Counter wrap from all ones
    imem_ack = 1'b0;
    force dut.retired = 16'hFFFF;
    @(negedge clk);
    release dut.retired;
    exp_ret = 16'hFFFF;
    run_instr(5'd1, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, -1);
    chk("wrap_retired", retired, 16'h0000);

    for (int n = 0; n < 250; n++) begin
      cls = int'($urandom_range(0, 4));
      case (cls)
        0, 1: op = 5'($urandom_range(0, 15));
        2: op = 5'd16;
        3: op = 5'd17;
        default: op = 5'd31;
      endcase
      run_instr(op, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have these ports: clk, input, 1, the only clock; all state changes occur on its rising edge.
REQ-002 reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-003 opcode, input, 5, decoded class: 00000-01111 = ALU ops, 10000 = load/store, 10001 = branch, 11111 = invalid.
REQ-004 cond, input, 4, ARM condition field.
REQ-005 flags, input, 4, current CPSR {N,Z,C,V}.
REQ-006 CPSRwrite, linkBit, loadStore, writeBack: inputs, 1 bit each, decoded S, L, L/S (1 = load) and W bits.
REQ-007 imem_ack, input, 1, instruction memory has returned a word.
REQ-008 dmem_ack, input, 1, data memory access is complete.
REQ-009 imem_req, output, 1, instruction fetch request.
REQ-010 dmem_req, output, 1, data memory request.
REQ-011 memRead and memWrite, outputs, 1 bit each, data memory direction qualifiers.
REQ-012 irWrite, pcWrite, pcSrc (0 = PC+4, 1 = branch target), regWrite, flagWrite, linkWrite and baseWrite: outputs, 1 bit each.
REQ-013 state, output, 3, current FSM state.
REQ-014 retired, output, 16, count of completed instructions.

Function
REQ-015 The FSM SHALL encode its states as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5; codes 6 and 7 SHALL return to FETCH on the next cycle with no control outputs asserted.
REQ-016 In FETCH:
- imem_req SHALL be 1 every cycle until imem_ack is sampled 1.
- In the cycle imem_ack=1, irWrite, pcWrite and pcSrc=0 SHALL all be asserted, and the next state SHALL be DECODE.
REQ-017 In DECODE, the block SHALL evaluate cond against flags using ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 = never.
REQ-018 In DECODE, if the condition fails or opcode=11111, the next state SHALL be FETCH with no side effects, and retired SHALL increment.
REQ-019 In DECODE, if the condition passes: opcode 10001 -> BRANCH; opcode 10000 or 0xxxx -> EXEC.
REQ-020 BRANCH SHALL last one cycle:
- pcWrite=1, pcSrc=1.
- linkWrite=linkBit.
- retired increments; next state FETCH.
REQ-021 EXEC for an ALU op SHALL last one cycle:
- flagWrite=1 if CPSRwrite=1 or opcode is in 01000-01011 (TST, TEQ, CMP, CMN).
- Compare ops: next state FETCH and retired increments.
- Other ALU ops: next state WB.
REQ-022 EXEC for load/store SHALL last one cycle (address compute), then go to MEM; flagWrite SHALL stay 0.
REQ-023 In MEM:
- dmem_req=1, memRead=loadStore and memWrite=~loadStore SHALL be held until dmem_ack is sampled 1.
- In the ack cycle, baseWrite=writeBack.
- Next state: WB if load; FETCH if store, with retired incrementing.
REQ-024 WB SHALL last one cycle: regWrite=1, retired increments, next state FETCH.
REQ-025 Every control output not explicitly asserted in a state SHALL be 0; all control outputs SHALL be Moore/Mealy functions of the current state and inputs, with no registered delay.
REQ-026 Ack inputs SHALL be ignored outside their owning state; an ack sampled in the first cycle of a request SHALL complete it, so the minimum is one cycle.
REQ-027 retired SHALL wrap from 16'hFFFF to 16'h0000 without flagging.
REQ-028 Decoded inputs SHALL be sampled in the state that uses them; the block SHALL NOT latch them.

Reset
REQ-029 While reset=0: state=FETCH(0), retired=0, and all control outputs 0, including imem_req; these values SHALL apply immediately, without waiting for a clock edge.
REQ-030 On the first rising clk after reset deasserts, the block SHALL be in FETCH with imem_req=1.
REQ-031 Reset asserted mid-MEM or mid-FETCH SHALL drop dmem_req/imem_req within the same cycle; no write strobe SHALL occur.

Verification
REQ-032 ADD with cond=1110 (AL), imem_ack after 2 wait cycles -> states FETCH x3, DECODE, EXEC, WB; irWrite exactly once; regWrite in WB; retired 0->1.
REQ-033 CMP with CPSRwrite=0 -> flagWrite=1 in EXEC, regWrite never asserted, EXEC->FETCH; retired increments.
REQ-034 BEQ with flags=0100 and linkBit=1 -> BRANCH with pcWrite=1, pcSrc=1, linkWrite=1; with flags=0000 -> DECODE->FETCH, pcWrite=0 after fetch.
REQ-035 LDR with writeBack=1, dmem_ack after 3 cycles -> memRead=1 and dmem_req=1 for 4 cycles, baseWrite=1 on the ack cycle, then WB regWrite=1; STR -> memWrite=1, no WB.
REQ-036 Reset pulse low during MEM -> dmem_req falls asynchronously, state=0, retired=0; then preload retired=16'hFFFF and retire one instruction -> 16'h0000.
REQ-037 Opcode 11111 with cond AL -> DECODE->FETCH, no write strobes, retired increments.
